// File: rtl/alu_pkg.sv
// Shared definitions for the alu_arbiter slice.
// Contents:
//   DATA_W    - alu datapath width (8)
//   OP_*      - 3-bit opcode encodings understood by the alu
//   state_t   - arbiter FSM state encoding
//   op_legal  - true for opcodes the alu defines (000..100)
package alu_pkg;

  localparam int DATA_W = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [2:0] sel);
    return (sel <= OP_NOT);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 8-bit alu.
// Ports:
//   A, B      - operands
//   ALU_Sel   - opcode (see alu_pkg OP_*); undefined opcodes yield zero
//   ALU_Out   - result
//   CarryOut  - carry out of add, borrow out of sub, 0 otherwise
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [2:0]        ALU_Sel,
  output logic [DATA_W-1:0] ALU_Out,
  output logic              CarryOut
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};

  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves
    // a value unassigned and no latch is inferred.
    ALU_Out  = '0;
    CarryOut = 1'b0;
    case (ALU_Sel)
      OP_ADD:  {CarryOut, ALU_Out} = sum;
      OP_SUB:  {CarryOut, ALU_Out} = diff;
      OP_AND:  ALU_Out = A & B;
      OP_OR:   ALU_Out = A | B;
      OP_NOT:  ALU_Out = ~A;
      default: ALU_Out = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared alu.
// One operation is accepted in IDLE, executed in EXEC (result registered),
// and presented in RESP until the consumer takes it.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   reqN_valid / reqN_ready  - request handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b, reqN_sel - operands and opcode of requester N
//   rsp_valid / rsp_ready    - response handshake
//   rsp_id                   - requester that owns the response
//   rsp_out, rsp_carry       - alu result and carry (zero on illegal opcode)
//   rsp_err                  - illegal opcode flag
//   busy                     - FSM is not in IDLE
module alu_arbiter
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_out,
  output logic              rsp_carry,
  output logic              rsp_err,
  output logic              busy
);

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;
  logic              grant_id;
  logic              accept;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [2:0]        op_sel;
  logic              op_id;

  logic [DATA_W-1:0] alu_out;
  logic              alu_carry;

  // Grant and handshake. On a tie the requester not granted last wins;
  // a lone requester always wins. Ready is gated by rst so nothing is
  // accepted during the reset cycle.
  always_comb begin
    grant_id   = 1'b0;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = req1_valid;
    end
    accept     = (state == ST_IDLE) && !rst && (req0_valid || req1_valid);
    req0_ready = accept && !grant_id;
    req1_ready = accept &&  grant_id;
  end

  // RESP always returns to IDLE for at least one cycle, so a new operation
  // can never be accepted in the cycle the response is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)    state_nxt = ST_EXEC;
      ST_EXEC:                state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;       // req0 wins the first tie
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= grant_id;
      end
    end
  end

  // NOTE: the operand latch has no reset; it is always loaded on acceptance
  // before EXEC reads it, so its power-up contents are never observed.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a   <= grant_id ? req1_a   : req0_a;
      op_b   <= grant_id ? req1_b   : req0_b;
      op_sel <= grant_id ? req1_sel : req0_sel;
      op_id  <= grant_id;
    end
  end

  alu u_alu (
    .A        (op_a),
    .B        (op_b),
    .ALU_Sel  (op_sel),
    .ALU_Out  (alu_out),
    .CarryOut (alu_carry)
  );

  // Response registers load once in EXEC and then hold through RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_id    <= 1'b0;
      rsp_out   <= '0;
      rsp_carry <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (state == ST_EXEC) begin
      rsp_id <= op_id;
      if (op_legal(op_sel)) begin
        rsp_out   <= alu_out;
        rsp_carry <= alu_carry;
        rsp_err   <= 1'b0;
      end else begin
        rsp_out   <= '0;
        rsp_carry <= 1'b0;
        rsp_err   <= 1'b1;
      end
    end
  end

  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_sel, req1_sel;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err, busy;
  logic [7:0] rsp_out;

  int n_tests = 0;
  int n_fail  = 0;

  alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sel   (req0_sel),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sel   (req1_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_out    (rsp_out),
    .rsp_carry  (rsp_carry),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_a = 8'h00; req0_b = 8'h00; req0_sel = 3'b000;
    req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; req1_sel = 3'b000;
    rsp_ready  = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits (bounded) for an acceptance in the current cycle; returns the
  // granted requester.
  task automatic wait_grant(input string tag, output logic gid);
    int n;
    n = 0;
    #1;
    while (!(req0_ready || req1_ready) && n < 8) begin
      tick();
      #1;
      n++;
    end
    check({tag, "_grant_seen"}, 32'(req0_ready || req1_ready), 32'd1);
    check({tag, "_one_ready"}, 32'(req0_ready && req1_ready), 32'd0);
    gid = req1_ready;
  endtask

  // Called in the acceptance cycle N: checks nothing valid at N+1 and the
  // full response at N+2. Optionally disturbs requester 0 after acceptance.
  task automatic expect_rsp(input string tag, input logic id, input logic [7:0] out,
                            input logic carry, input logic err, input bit chk_carry,
                            input bit scramble);
    tick();
    if (scramble) begin
      req0_valid = 1'b0; req0_a = 8'h77; req0_b = 8'h33; req0_sel = 3'b001;
    end
    #1;
    check({tag, "_lat_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_exec_busy"}, 32'(busy), 32'd1);
    check({tag, "_exec_ready"}, 32'(req0_ready || req1_ready), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_id"}, 32'(rsp_id), 32'(id));
    check({tag, "_out"}, 32'(rsp_out), 32'(out));
    check({tag, "_err"}, 32'(rsp_err), 32'(err));
    if (chk_carry) check({tag, "_carry"}, 32'(rsp_carry), 32'(carry));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic gid;

    // Reset state, with a requester already valid during reset.
    idle_inputs();
    rst = 1'b1;
    req0_valid = 1'b1;
    tick();
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out", 32'(rsp_out), 32'h00);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_carry", 32'(rsp_carry), 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    req0_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Single add 01+09, operands disturbed after acceptance.
    req0_valid = 1'b1; req0_sel = 3'b000; req0_a = 8'h01; req0_b = 8'h09;
    rsp_ready  = 1'b1;
    wait_grant("add", gid);
    check("add_gid", 32'(gid), 32'd0);
    expect_rsp("add", 1'b0, 8'h0A, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check("add_done_valid", 32'(rsp_valid), 32'd0);
    check("add_done_busy", 32'(busy), 32'd0);

    // Tie: req0 sub 0A-02 first, then req1 and FF&0F.
    idle_inputs();
    reset_dut();
    rsp_ready  = 1'b1;
    req0_valid = 1'b1; req0_sel = 3'b001; req0_a = 8'h0A; req0_b = 8'h02;
    req1_valid = 1'b1; req1_sel = 3'b010; req1_a = 8'hFF; req1_b = 8'h0F;
    wait_grant("tie0", gid);
    check("tie0_gid", 32'(gid), 32'd0);
    expect_rsp("tie0", 1'b0, 8'h08, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    wait_grant("tie1", gid);
    check("tie1_gid", 32'(gid), 32'd1);
    expect_rsp("tie1", 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Back-pressure: req1 or F0|0F held 5 cycles; req0 waits meanwhile.
    idle_inputs();
    reset_dut();
    req1_valid = 1'b1; req1_sel = 3'b011; req1_a = 8'hF0; req1_b = 8'h0F;
    wait_grant("bp", gid);
    check("bp_gid", 32'(gid), 32'd1);
    expect_rsp("bp", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_sel = 3'b000; req0_a = 8'h11; req0_b = 8'h22;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_out", 32'(rsp_out), 32'hFF);
      check("bp_hold_id", 32'(rsp_id), 32'd1);
      check("bp_hold_ready", 32'(req0_ready || req1_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_exit_ready", 32'(req0_ready || req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;   // withdrawn before it could be accepted
    rsp_ready  = 1'b0;
    #1;
    check("bp_idle_valid", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_no_phantom_busy", 32'(busy), 32'd0);
      check("bp_single_rsp", 32'(rsp_valid), 32'd0);
    end

    // Illegal opcode 110, then legal not A.
    idle_inputs();
    reset_dut();
    rsp_ready  = 1'b1;
    req0_valid = 1'b1; req0_sel = 3'b110; req0_a = 8'hAA; req0_b = 8'h00;
    wait_grant("ill", gid);
    expect_rsp("ill", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    req0_sel = 3'b100;
    wait_grant("not", gid);
    expect_rsp("not", 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    req0_valid = 1'b0;
    tick();

    // Reset in EXEC discards the operation.
    idle_inputs();
    reset_dut();
    rsp_ready  = 1'b1;
    req0_valid = 1'b1; req0_sel = 3'b000; req0_a = 8'h03; req0_b = 8'h04;
    wait_grant("rexec", gid);
    tick();
    req0_valid = 1'b0;
    #1;
    check("rexec_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rexec_idle", 32'(busy), 32'd0);
    check("rexec_valid", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rexec_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // Continuous FF+01 from both: grants alternate starting with req0.
    idle_inputs();
    reset_dut();
    rsp_ready  = 1'b1;
    req0_valid = 1'b1; req0_sel = 3'b000; req0_a = 8'hFF; req0_b = 8'h01;
    req1_valid = 1'b1; req1_sel = 3'b000; req1_a = 8'hFF; req1_b = 8'h01;
    for (int k = 0; k < 4; k++) begin
      logic exp_id;
      exp_id = logic'(k % 2);
      wait_grant("rr", gid);
      check("rr_gid", 32'(gid), 32'(exp_id));
      expect_rsp("rr", exp_id, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
    end
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
